// File: rtl/token_ctrl_pkg.sv
// rtl/token_ctrl_pkg.sv - shared state encoding, default widths and counter sizing for token_access_controller
package token_ctrl_pkg;

  localparam int DEF_TOKEN_W = 3;
  localparam int DEF_DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AUTH   = 3'd1,
    ST_ARMED  = 3'd2,
    ST_EVAL   = 3'd3,
    ST_DONE   = 3'd4,
    ST_LOCKED = 3'd5
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/data_reg.sv
// rtl/data_reg.sv - load-enabled data register with synchronous active-high clear
module data_reg
  import token_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clock) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/token_access_controller.sv
// rtl/token_access_controller.sv - token-authenticated request controller classifying one time_data sample into P or Q
module token_access_controller
  import token_ctrl_pkg::*;
#(
  parameter int                TOKEN_W     = DEF_TOKEN_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter logic [DATA_W-1:0] MATCH_MASK  = DATA_W'('h0F),
  parameter logic [DATA_W-1:0] MATCH_VAL   = DATA_W'('h0F),
  parameter int                MAX_TRIES   = 3,
  parameter int                TIMEOUT_CYC = 16,
  parameter int                LOCK_CYC    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               request,
  input  logic               confirm,
  input  logic [TOKEN_W-1:0] user_token,
  input  logic [TOKEN_W-1:0] system_token,
  input  logic [DATA_W-1:0]  time_data,
  output logic [DATA_W-1:0]  data_p,
  output logic [DATA_W-1:0]  data_q,
  output logic               p_valid,
  output logic               q_valid,
  output logic               timeout,
  output logic               locked,
  output logic               busy
);

  localparam int TIMER_W = cnt_width(TIMEOUT_CYC);
  localparam int LOCK_W  = cnt_width(LOCK_CYC + 1);
  localparam int TRY_W   = cnt_width(MAX_TRIES + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_CYC - 1);
  localparam logic [TRY_W-1:0]   TRY_LAST   = TRY_W'(MAX_TRIES - 1);

  state_t             state, state_d;
  logic [TIMER_W-1:0] timer, timer_d;
  logic [LOCK_W-1:0]  lock_cnt, lock_d;
  logic [TRY_W-1:0]   try_cnt, try_d;
  logic               confirm_q;
  logic               confirm_edge;
  logic               tokens_equal;
  logic               match;
  logic               load_p, load_q, timeout_d;

  assign confirm_edge = confirm & ~confirm_q;
  assign tokens_equal = (user_token == system_token);
  assign match        = ((time_data & MATCH_MASK) == MATCH_VAL);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      lock_cnt  <= '0;
      try_cnt   <= '0;
      confirm_q <= 1'b0;
      p_valid   <= 1'b0;
      q_valid   <= 1'b0;
      timeout   <= 1'b0;
      locked    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      lock_cnt  <= lock_d;
      try_cnt   <= try_d;
      confirm_q <= confirm;
      p_valid   <= load_p;
      q_valid   <= load_q;
      timeout   <= timeout_d;
      locked    <= (state_d == ST_LOCKED);
      busy      <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    lock_d    = lock_cnt;
    try_d     = try_cnt;
    load_p    = 1'b0;
    load_q    = 1'b0;
    timeout_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (request) begin
          state_d = ST_AUTH;
          timer_d = '0;
        end
      end
      ST_AUTH: begin
        if (!request) begin
          state_d = ST_IDLE;
        end else if (confirm_edge) begin
          if (tokens_equal) begin
            state_d = ST_ARMED;
            try_d   = '0;
            timer_d = '0;
          end else if (try_cnt == TRY_LAST) begin
            state_d = ST_LOCKED;
            try_d   = '0;
            lock_d  = '0;
          end else begin
            try_d   = try_cnt + TRY_W'(1);
            timer_d = '0;
          end
        end else if (timer == TIMER_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer + TIMER_W'(1);
        end
      end
      ST_ARMED: begin
        if (!request) begin
          state_d = ST_IDLE;
        end else if (confirm_edge) begin
          state_d = ST_EVAL;
        end else if (timer == TIMER_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer + TIMER_W'(1);
        end
      end
      ST_EVAL: begin
        // A session dropped during EVAL must leave both data registers untouched.
        if (!request) begin
          state_d = ST_IDLE;
        end else begin
          load_p  = match;
          load_q  = ~match;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!request) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (lock_cnt == LOCK_LAST) begin
          state_d = ST_IDLE;
        end else begin
          lock_d = lock_cnt + LOCK_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  data_reg #(.DATA_W(DATA_W)) u_reg_p (
    .clock (clock),
    .clear (reset),
    .load  (load_p),
    .d     (time_data),
    .q     (data_p)
  );

  data_reg #(.DATA_W(DATA_W)) u_reg_q (
    .clock (clock),
    .clear (reset),
    .load  (load_q),
    .d     (time_data),
    .q     (data_q)
  );

endmodule

// File: tb/tb_token_access_controller.sv
// tb/tb_token_access_controller.sv - table-driven self-checking bench for token_access_controller
module tb_token_access_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       request;
  logic       confirm;
  logic [2:0] user_token;
  logic [2:0] system_token;
  logic [7:0] time_data;
  logic [7:0] data_p;
  logic [7:0] data_q;
  logic       p_valid, q_valid, timeout, locked, busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       req;
    logic       conf;
    logic [2:0] ut;
    logic [2:0] st;
    logic [7:0] td;
    logic [7:0] dp;
    logic [7:0] dq;
    logic       pv;
    logic       qv;
    logic       to;
    logic       lk;
    logic       bz;
  } vec_t;

  vec_t vecs[$];

  token_access_controller dut (
    .clock        (clock),
    .reset        (reset),
    .request      (request),
    .confirm      (confirm),
    .user_token   (user_token),
    .system_token (system_token),
    .time_data    (time_data),
    .data_p       (data_p),
    .data_q       (data_q),
    .p_valid      (p_valid),
    .q_valid      (q_valid),
    .timeout      (timeout),
    .locked       (locked),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  function automatic void add(input int req, input int conf, input int ut, input int st, input int td,
                              input int dp, input int dq, input int pv, input int qv, input int to,
                              input int lk, input int bz);
    vec_t v;
    v.req  = 1'(req);
    v.conf = 1'(conf);
    v.ut   = 3'(ut);
    v.st   = 3'(st);
    v.td   = 8'(td);
    v.dp   = 8'(dp);
    v.dq   = 8'(dq);
    v.pv   = 1'(pv);
    v.qv   = 1'(qv);
    v.to   = 1'(to);
    v.lk   = 1'(lk);
    v.bz   = 1'(bz);
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic rst, input logic req, input logic conf, input logic [2:0] ut,
                       input logic [2:0] st, input logic [7:0] td);
    @(negedge clock);
    reset        = rst;
    request      = req;
    confirm      = conf;
    user_token   = ut;
    system_token = st;
    time_data    = td;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] edp, input logic [7:0] edq, input logic epv,
                       input logic eqv, input logic eto, input logic elk, input logic ebz);
    n_vec++;
    if ({data_p, data_q, p_valid, q_valid, timeout, locked, busy} !==
        {edp, edq, epv, eqv, eto, elk, ebz}) begin
      n_bad++;
      $display("FAIL %s: got dp=%h dq=%h pv=%b qv=%b to=%b lk=%b bz=%b, want dp=%h dq=%h pv=%b qv=%b to=%b lk=%b bz=%b",
               tag, data_p, data_q, p_valid, q_valid, timeout, locked, busy,
               edp, edq, epv, eqv, eto, elk, ebz);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // P session: tokens match, 2F & 0F == 0F; extra confirms in DONE must not pulse
    add(1,0,5,5,'h2F, 'h00,'h00, 0,0,0,0,1);
    add(1,1,5,5,'h2F, 'h00,'h00, 0,0,0,0,1);
    add(1,0,5,5,'h2F, 'h00,'h00, 0,0,0,0,1);
    add(1,1,5,5,'h2F, 'h00,'h00, 0,0,0,0,1);
    add(1,1,5,5,'h2F, 'h2F,'h00, 1,0,0,0,1);
    add(1,0,5,5,'h2F, 'h2F,'h00, 0,0,0,0,1);
    add(1,1,5,5,'h2F, 'h2F,'h00, 0,0,0,0,1);
    add(1,0,5,5,'h2F, 'h2F,'h00, 0,0,0,0,1);
    add(1,1,5,5,'h2F, 'h2F,'h00, 0,0,0,0,1);
    add(0,0,5,5,'h2F, 'h2F,'h00, 0,0,0,0,0);
    // Q session: 2E fails the match rule
    add(1,0,5,5,'h2E, 'h2F,'h00, 0,0,0,0,1);
    add(1,1,5,5,'h2E, 'h2F,'h00, 0,0,0,0,1);
    add(1,0,5,5,'h2E, 'h2F,'h00, 0,0,0,0,1);
    add(1,1,5,5,'h2E, 'h2F,'h00, 0,0,0,0,1);
    add(1,0,5,5,'h2E, 'h2F,'h2E, 0,1,0,0,1);
    add(1,0,5,5,'h2E, 'h2F,'h2E, 0,0,0,0,1);
    add(0,0,5,5,'h2E, 'h2F,'h2E, 0,0,0,0,0);
    // request dropped on the ARMED confirm edge
    add(1,0,5,5,'h5F, 'h2F,'h2E, 0,0,0,0,1);
    add(1,1,5,5,'h5F, 'h2F,'h2E, 0,0,0,0,1);
    add(1,0,5,5,'h5F, 'h2F,'h2E, 0,0,0,0,1);
    add(0,1,5,5,'h5F, 'h2F,'h2E, 0,0,0,0,0);
    add(0,0,5,5,'h5F, 'h2F,'h2E, 0,0,0,0,0);
    // request dropped during EVAL
    add(1,0,5,5,'h5F, 'h2F,'h2E, 0,0,0,0,1);
    add(1,1,5,5,'h5F, 'h2F,'h2E, 0,0,0,0,1);
    add(1,0,5,5,'h5F, 'h2F,'h2E, 0,0,0,0,1);
    add(1,1,5,5,'h5F, 'h2F,'h2E, 0,0,0,0,1);
    add(0,0,5,5,'h5F, 'h2F,'h2E, 0,0,0,0,0);
    add(0,0,5,5,'h5F, 'h2F,'h2E, 0,0,0,0,0);
    // three mismatching confirms -> LOCKED for 8 cycles, inputs ignored
    add(1,0,1,6,'h00, 'h2F,'h2E, 0,0,0,0,1);
    for (int i = 0; i < 2; i++) begin
      add(1,1,1,6,'h00, 'h2F,'h2E, 0,0,0,0,1);
      add(1,0,1,6,'h00, 'h2F,'h2E, 0,0,0,0,1);
    end
    add(1,1,1,6,'h00, 'h2F,'h2E, 0,0,0,1,1);
    for (int i = 0; i < 8; i++) begin
      add(1, i % 2, 5,5,'h00, 'h2F,'h2E, 0,0,0, (i < 7) ? 1 : 0, (i < 7) ? 1 : 0);
    end
    // session after lockout authenticates normally
    add(1,0,5,5,'h4F, 'h2F,'h2E, 0,0,0,0,1);
    add(1,1,5,5,'h4F, 'h2F,'h2E, 0,0,0,0,1);
    add(1,0,5,5,'h4F, 'h2F,'h2E, 0,0,0,0,1);
    add(1,1,5,5,'h4F, 'h2F,'h2E, 0,0,0,0,1);
    add(1,0,5,5,'h4F, 'h4F,'h2E, 1,0,0,0,1);
    add(0,0,5,5,'h4F, 'h4F,'h2E, 0,0,0,0,0);
    // 16 idle AUTH cycles -> timeout pulse
    add(1,0,5,5,'h00, 'h4F,'h2E, 0,0,0,0,1);
    for (int i = 0; i < 15; i++) begin
      add(1,0,5,5,'h00, 'h4F,'h2E, 0,0,0,0,1);
    end
    add(1,0,5,5,'h00, 'h4F,'h2E, 0,0,1,0,0);
    add(0,0,5,5,'h00, 'h4F,'h2E, 0,0,0,0,0);
    // confirm held high 20 cycles in ARMED -> one EVAL only
    add(1,0,5,5,'h3E, 'h4F,'h2E, 0,0,0,0,1);
    add(1,1,5,5,'h3E, 'h4F,'h2E, 0,0,0,0,1);
    add(1,0,5,5,'h3E, 'h4F,'h2E, 0,0,0,0,1);
    add(1,1,5,5,'h3E, 'h4F,'h2E, 0,0,0,0,1);
    add(1,1,5,5,'h3E, 'h4F,'h3E, 0,1,0,0,1);
    for (int i = 0; i < 18; i++) begin
      add(1,1,5,5,'h3E, 'h4F,'h3E, 0,0,0,0,1);
    end
    add(0,0,5,5,'h3E, 'h4F,'h3E, 0,0,0,0,0);

    reset = 1'b1; request = 1'b0; confirm = 1'b0;
    user_token = 3'd0; system_token = 3'd0; time_data = 8'h00;
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00);
    check("reset_state", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].req, vecs[i].conf, vecs[i].ut, vecs[i].st, vecs[i].td);
      check($sformatf("vec%0d", i), vecs[i].dp, vecs[i].dq, vecs[i].pv, vecs[i].qv,
            vecs[i].to, vecs[i].lk, vecs[i].bz);
    end

    // reset while ARMED clears state and both data registers
    drive(1'b0, 1'b1, 1'b0, 3'd5, 3'd5, 8'h2F);
    drive(1'b0, 1'b1, 1'b1, 3'd5, 3'd5, 8'h2F);
    drive(1'b0, 1'b1, 1'b0, 3'd5, 3'd5, 8'h2F);
    check("armed_busy", 8'h4F, 8'h3E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 3'd5, 3'd5, 8'h2F);
    check("reset_mid_armed", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 3'd5, 3'd5, 8'h2F);
    check("idle_after_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
